gate_truth_table_tester: RTL and testbench
==========================================

Name: gate_truth_table_tester

Overview:
- Self-contained sequential tester for a 2-input combinational gate. Sits on both sides of the gate: drives the gate's `a`/`b` inputs upstream and consumes its `y` output downstream.
- On `start`, walks all four input vectors {a,b} = 00, 01, 10, 11 in order.
- Waits a programmable settle time per vector, samples `y`, and compares it against an expected truth table.
- Reports pass/fail, error count and the first failing vector. Replaces hand-written `#delay` stimulus in gate benches with a clocked, reusable stage.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a vector and sampling `y`. Legal range 1..15; any other value is a synthesis/elaboration error.
- EXPECT_TT, 4'b0111: expected `y` per vector; bit i is the expected `y` when {a,b} = i. The default is NAND.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a test run; sampled on rising edge, ignored while busy=1
- a  output  1  gate input A (MSB of vector index)
- b  output  1  gate input B (LSB of vector index)
- y  input  1  gate output under test
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when the last completed run had zero mismatches
- err_count  output  3  mismatches in the last/current run, 0..4
- first_fail_vec  output  2  {a,b} of the first mismatching vector
- first_fail_valid  output  1  first_fail_vec holds a real failure

Behaviour:
- Reset (rst_n low, asynchronous): a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=00, first_fail_valid=0.
  - Internal state goes to IDLE; vector index and settle counter clear.
  - Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- States:
  - IDLE: a=b=0, busy=0.
  - RUN: busy=1, stepping through vectors.
  - The done pulse is a registered flag, not a separate state.
- IDLE -> RUN on the rising edge E0 where start=1. At E0:
  - {a,b} <= 00, index <= 0, settle counter loads SETTLE_CYCLES, busy <= 1.
  - err_count <= 0, first_fail_valid <= 0, first_fail_vec <= 00, pass <= 0.
- Timing: vector k is driven at edge E0 + k*SETTLE_CYCLES. `y` for vector k is sampled at edge E0 + (k+1)*SETTLE_CYCLES.
- At each sample edge:
  - Mismatch when y != EXPECT_TT[index]. In simulation, X or Z on `y` counts as a mismatch (case-inequality compare).
  - On mismatch: err_count increments by 1, saturating at 4 (never wraps).
  - On the first mismatch of the run: first_fail_vec <= index and first_fail_valid <= 1. Later mismatches do not overwrite them.
  - If index < 3: index increments, {a,b} <= new index, counter reloads.
  - If index = 3: state <= IDLE, {a,b} <= 00, busy <= 0, done <= 1, pass <= (no mismatch in the whole run, including this sample).
- Total run: busy high for exactly 4*SETTLE_CYCLES cycles. done is high for the single cycle after edge E0 + 4*SETTLE_CYCLES.
- done self-clears on the next edge.
- pass, err_count, first_fail_vec and first_fail_valid hold until the next accepted start or reset.
- start while busy=1: ignored; no effect on the current run.
- start high in the cycle where done=1 (state already IDLE): accepted as a new E0. done clears at that edge and results are cleared per the start rule.
- start held continuously high: back-to-back runs with no idle gap beyond the done cycle.
- All outputs are registered; `y` is the only input on a combinational compare path.

Test Plan:
- Correct NAND connected, SETTLE_CYCLES=2, start pulse at E0:
  - {a,b} sequence 00,01,10,11 at E0, E0+2, E0+4, E0+6.
  - done pulse after E0+8; pass=1, err_count=0, first_fail_valid=0.
- `y` tied to 1 (stuck-at-1), default EXPECT_TT -> only vector 11 fails: err_count=1, first_fail_vec=11, first_fail_valid=1, pass=0.
- AND gate connected (y=a&b) against NAND table -> all four vectors fail: err_count=4 (no wrap), first_fail_vec=00, pass=0.
- Start pulses at E0+3 and E0+5 during a run: ignored, run timing unchanged. start asserted in the done cycle: new run begins, busy=1 next cycle, results cleared.
- rst_n low at E0+3 mid-run: all outputs 0 immediately (asynchronous), no done pulse. After release, a fresh start with NAND passes.
- SETTLE_CYCLES=1, EXPECT_TT=4'b1000 (AND), AND connected: vectors change every cycle, done after E0+4, pass=1.

Source files
------------

// File: rtl/gate_truth_table_tester.sv
// rtl/gate_truth_table_tester.sv - clocked exhaustive truth-table tester for a 2-input gate
module gate_truth_table_tester #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT_TT     = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gate_truth_table_tester: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [1:0] ffvec_q, ffvec_d;
    logic       ffvalid_q, ffvalid_d;
    logic       mismatch;

    // Case-inequality so an X/Z gate output is treated as a failure.
    always_comb begin
        mismatch = (y !== EXPECT_TT[idx_q]);
    end

    // Next-state logic: accept start in IDLE, step vectors and grade samples in RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = 2'd0;
                    cnt_d     = SETTLE_LD;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    err_d     = 3'd0;
                    ffvec_d   = 2'd0;
                    ffvalid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd1) begin
                    // Sample edge for the vector currently on a/b.
                    if (mismatch) begin
                        err_d = (err_q == 3'd4) ? 3'd4 : err_q + 3'd1;
                        if (!ffvalid_q) begin
                            ffvec_d   = idx_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE_LD;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == 3'd0) && !mismatch;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 3'd0;
            ffvec_q   <= 2'd0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // The vector index register drives the gate directly; it is 0 whenever idle.
    assign a                = idx_q[1];
    assign b                = idx_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_truth_table_tester.sv
// tb/tb_gate_truth_table_tester.sv - directed-vector bench for gate_truth_table_tester
module tb_gate_truth_table_tester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       a0, b0, y0, busy0, done0, pass0, ffv0;
    logic [2:0] err0;
    logic [1:0] ffvec0;
    logic       a1, b1, y1, busy1, done1, pass1, ffv1;
    logic [2:0] err1;
    logic [1:0] ffvec1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Gate models: 0 = NAND, 1 = stuck-at-1, 2 = AND
    assign y0 = (mode == 2'd0) ? ~(a0 & b0) : (mode == 2'd1) ? 1'b1 : (a0 & b0);
    assign y1 = a1 & b1;

    gate_truth_table_tester #(.SETTLE_CYCLES(2), .EXPECT_TT(4'b0111)) u_nand (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_valid(ffv0)
    );

    gate_truth_table_tester #(.SETTLE_CYCLES(1), .EXPECT_TT(4'b1000)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
    );

    logic [1:0] o_ab, o_ffvec;
    logic [2:0] o_err;
    logic       o_busy, o_done, o_pass, o_ffv;
    assign o_ab    = sel ? {a1, b1} : {a0, b0};
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_pass  = sel ? pass1 : pass0;
    assign o_err   = sel ? err1 : err0;
    assign o_ffvec = sel ? ffvec1 : ffvec0;
    assign o_ffv   = sel ? ffv1 : ffv0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag, input int e_err, input int e_ffvec,
                                 input bit e_ffv, input bit e_pass);
        check({tag, " err_count"}, 8'(o_err), 8'(e_err));
        check({tag, " first_fail_vec"}, 8'(o_ffvec), 8'(e_ffvec));
        check({tag, " first_fail_valid"}, 8'(o_ffv), 8'(e_ffv));
        check({tag, " pass"}, 8'(o_pass), 8'(e_pass));
    endtask

    // Pulse start, then walk every edge of the run checking a/b, busy, done, results.
    task automatic run_check(input string tag, input int s, input int e_err, input int e_ffvec,
                             input bit e_ffv, input bit e_pass, input bit mid_start,
                             input bit restart);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= 4 * s; j++) begin
            check($sformatf("%s ab@E0+%0d", tag, j), 8'(o_ab), (j < 4 * s) ? 8'(j / s) : 8'd0);
            check($sformatf("%s busy@E0+%0d", tag, j), 8'(o_busy), 8'(j < 4 * s));
            check($sformatf("%s done@E0+%0d", tag, j), 8'(o_done), 8'(j == 4 * s));
            if (j < 4 * s) begin
                start = mid_start && (j == 2 || j == 4);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_results(tag, e_err, e_ffvec, e_ffv, e_pass);
        if (restart) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " restart done"}, 8'(o_done), 8'd0);
            check({tag, " restart busy"}, 8'(o_busy), 8'd1);
            check_results({tag, " restart cleared"}, 0, 0, 1'b0, 1'b0);
        end else begin
            @(negedge clk);
            check({tag, " done cleared"}, 8'(o_done), 8'd0);
            check({tag, " busy idle"}, 8'(o_busy), 8'd0);
            check_results({tag, " hold"}, e_err, e_ffvec, e_ffv, e_pass);
        end
    endtask

    initial begin
        #1;
        check("reset ab", 8'(o_ab), 8'd0);
        check("reset busy", 8'(o_busy), 8'd0);
        check("reset done", 8'(o_done), 8'd0);
        check_results("reset", 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 2'd0;
        run_check("nand", 2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        mode = 2'd1;
        run_check("stuck1", 2, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        mode = 2'd2;
        run_check("and_vs_nand", 2, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        mode = 2'd0;
        run_check("mid_start", 2, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Restart in the done cycle of a failing run; second run uses a good NAND.
        mode = 2'd1;
        run_check("b2b", 2, 1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        mode = 2'd0;
        repeat (7) @(negedge clk);
        check("b2b second busy", 8'(o_busy), 8'd1);
        check("b2b second done early", 8'(o_done), 8'd0);
        @(negedge clk);
        check("b2b second done", 8'(o_done), 8'd1);
        check_results("b2b second", 0, 0, 1'b0, 1'b1);
        @(negedge clk);

        // Asynchronous reset mid-run after a mismatch has been recorded.
        mode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset err", 8'(o_err), 8'd1);
        check("pre_reset ab", 8'(o_ab), 8'd1);
        rst_n = 1'b0;
        #1;
        check("async ab", 8'(o_ab), 8'd0);
        check("async busy", 8'(o_busy), 8'd0);
        check_results("async", 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("in_reset done %0d", k), 8'(o_done), 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'd0;
        run_check("post_reset nand", 2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // SETTLE_CYCLES=1 instance with AND table and AND gate.
        sel = 1'b1;
        #1;
        check("and1 idle busy", 8'(o_busy), 8'd0);
        run_check("and1", 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
